// File: rtl/proc_pkg.sv
// Shared encodings between the processor control FSM and the datapath:
// bus source codes, per-register strobe bit positions and ALU operations.
package proc_pkg;

    typedef enum logic [3:0] {
        SRC_NONE = 4'd0,
        SRC_PC   = 4'd1,
        SRC_AR   = 4'd2,
        SRC_DR   = 4'd3,
        SRC_OPND = 4'd4,
        SRC_AC   = 4'd5,
        SRC_R    = 4'd6,
        SRC_R1   = 4'd7,
        SRC_R2   = 4'd8,
        SRC_R3   = 4'd9,
        SRC_R4   = 4'd10,
        SRC_RSVD = 4'd11,
        SRC_DM   = 4'd12,
        SRC_IM   = 4'd13
    } src_e;

    // Note the strobe order for R1-R4 is the reverse of their bus codes.
    localparam int EN_PC     = 1;
    localparam int EN_AR     = 2;
    localparam int EN_IR     = 3;
    localparam int EN_AC     = 4;
    localparam int EN_R      = 5;
    localparam int EN_R4     = 7;
    localparam int EN_R3     = 8;
    localparam int EN_R2     = 9;
    localparam int EN_R1     = 10;
    localparam int EN_DM_WR  = 11;
    localparam int EN_ALU_AC = 12;
    localparam int EN_AC_R   = 13;

    typedef enum logic [2:0] {
        ALU_NOP = 3'd0,
        ALU_ADD = 3'd1,
        ALU_SUB = 3'd2,
        ALU_MUL = 3'd3,
        ALU_LSH = 3'd4
    } alu_op_e;

endpackage

// File: rtl/bus_reg.sv
// Generic architectural register: clear beats load beats increment, else hold.
module bus_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         inc_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (load_i) begin
            q_d = d_i;
        end else if (inc_i) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/datapath_bus.sv
// Register file and shared bus for the processor; AC, R and the ALU live here
// because they have load sources beyond the bus.
module datapath_bus
    import proc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        read_en,
    input  logic [15:0]       write_en,
    input  logic [15:0]       inc_en,
    input  logic [15:0]       clr_en,
    input  logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] im_rdata,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] im_addr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_we,
    output logic [5:0]        instruction,
    output logic [15:0]       z,
    output logic [DATA_W-1:0] bus
);

    logic [ADDR_W-1:0] pc_q, ar_q;
    logic [DATA_W-1:0] ir_q, r1_q, r2_q, r3_q, r4_q;
    logic [DATA_W-1:0] ac_q, ac_d, r_q, r_d, dr_q;
    logic [DATA_W-1:0] alu_res;
    logic              unused_strobes;

    always_comb begin
        bus = '0;
        case (read_en)
            SRC_PC:   bus = DATA_W'(pc_q);
            SRC_AR:   bus = DATA_W'(ar_q);
            SRC_DR:   bus = dr_q;
            SRC_OPND: bus = {6'b0, ir_q[DATA_W-1:6]};
            SRC_AC:   bus = ac_q;
            SRC_R:    bus = r_q;
            SRC_R1:   bus = r1_q;
            SRC_R2:   bus = r2_q;
            SRC_R3:   bus = r3_q;
            SRC_R4:   bus = r4_q;
            SRC_DM:   bus = dm_rdata;
            SRC_IM:   bus = im_rdata;
            default:  bus = '0;
        endcase
    end

    bus_reg #(.W(ADDR_W)) u_pc (.clk(clk), .rst_n(rst_n), .clr_i(clr_en[EN_PC]),
        .load_i(write_en[EN_PC]), .inc_i(inc_en[EN_PC]), .d_i(bus[ADDR_W-1:0]), .q_o(pc_q));
    bus_reg #(.W(ADDR_W)) u_ar (.clk(clk), .rst_n(rst_n), .clr_i(clr_en[EN_AR]),
        .load_i(write_en[EN_AR]), .inc_i(inc_en[EN_AR]), .d_i(bus[ADDR_W-1:0]), .q_o(ar_q));
    bus_reg #(.W(DATA_W)) u_ir (.clk(clk), .rst_n(rst_n), .clr_i(clr_en[EN_IR]),
        .load_i(write_en[EN_IR]), .inc_i(inc_en[EN_IR]), .d_i(bus), .q_o(ir_q));
    bus_reg #(.W(DATA_W)) u_r1 (.clk(clk), .rst_n(rst_n), .clr_i(clr_en[EN_R1]),
        .load_i(write_en[EN_R1]), .inc_i(inc_en[EN_R1]), .d_i(bus), .q_o(r1_q));
    bus_reg #(.W(DATA_W)) u_r2 (.clk(clk), .rst_n(rst_n), .clr_i(clr_en[EN_R2]),
        .load_i(write_en[EN_R2]), .inc_i(inc_en[EN_R2]), .d_i(bus), .q_o(r2_q));
    bus_reg #(.W(DATA_W)) u_r3 (.clk(clk), .rst_n(rst_n), .clr_i(clr_en[EN_R3]),
        .load_i(write_en[EN_R3]), .inc_i(inc_en[EN_R3]), .d_i(bus), .q_o(r3_q));
    bus_reg #(.W(DATA_W)) u_r4 (.clk(clk), .rst_n(rst_n), .clr_i(clr_en[EN_R4]),
        .load_i(write_en[EN_R4]), .inc_i(inc_en[EN_R4]), .d_i(bus), .q_o(r4_q));

    always_comb begin
        alu_res = ac_q;
        case (alu_op)
            ALU_ADD: alu_res = ac_q + r_q;
            ALU_SUB: alu_res = ac_q - r_q;
            ALU_MUL: alu_res = ac_q * r_q;
            ALU_LSH: alu_res = ac_q << 1;
            default: alu_res = ac_q;
        endcase
    end

    always_comb begin
        ac_d = ac_q;
        if (clr_en[EN_AC]) begin
            ac_d = '0;
        end else if (write_en[EN_AC]) begin
            ac_d = bus;
        end else if (write_en[EN_ALU_AC]) begin
            ac_d = alu_res;
        end else if (inc_en[EN_AC]) begin
            ac_d = ac_q + DATA_W'(1);
        end

        r_d = r_q;
        if (clr_en[EN_R]) begin
            r_d = '0;
        end else if (write_en[EN_R]) begin
            r_d = bus;
        end else if (write_en[EN_AC_R]) begin
            r_d = ac_q;
        end else if (inc_en[EN_R]) begin
            r_d = r_q + DATA_W'(1);
        end
    end

    // DR is a free-running one-cycle delay of the data memory read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_q <= '0;
            r_q  <= '0;
            dr_q <= '0;
        end else begin
            ac_q <= ac_d;
            r_q  <= r_d;
            dr_q <= dm_rdata;
        end
    end

    assign im_addr     = pc_q;
    assign dm_addr     = ar_q;
    assign dm_wdata    = bus;
    assign dm_we       = write_en[EN_DM_WR];
    assign instruction = ir_q[5:0];
    assign z           = {15'b0, (ac_q == '0)};

    assign unused_strobes = ^{write_en[0], write_en[6], write_en[15:14],
                              inc_en[0], inc_en[6], inc_en[15:11],
                              clr_en[0], clr_en[6], clr_en[15:11]};

endmodule

// File: tb/tb_datapath_bus.sv
// Bench for datapath_bus: directed scenarios then random strobes, all checked
// against a register-level reference model of the architectural state.
module tb_datapath_bus;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  read_en = '0;
    logic [15:0] write_en = '0, inc_en = '0, clr_en = '0;
    logic [2:0]  alu_op = '0;
    logic [15:0] im_rdata = '0, dm_rdata = '0;
    logic [15:0] im_addr, dm_addr, dm_wdata, z, bus;
    logic        dm_we;
    logic [5:0]  instruction;

    int total = 0;
    int bad = 0;

    logic [15:0] m_pc, m_ar, m_ir, m_ac, m_r, m_r1, m_r2, m_r3, m_r4, m_dr;

    datapath_bus #(.DATA_W(16), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .read_en(read_en), .write_en(write_en),
        .inc_en(inc_en), .clr_en(clr_en), .alu_op(alu_op),
        .im_rdata(im_rdata), .dm_rdata(dm_rdata), .im_addr(im_addr),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
        .instruction(instruction), .z(z), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mbus(input logic [3:0] re);
        case (re)
            4'd1:  return m_pc;
            4'd2:  return m_ar;
            4'd3:  return m_dr;
            4'd4:  return m_ir >> 6;
            4'd5:  return m_ac;
            4'd6:  return m_r;
            4'd7:  return m_r1;
            4'd8:  return m_r2;
            4'd9:  return m_r3;
            4'd10: return m_r4;
            4'd12: return dm_rdata;
            4'd13: return im_rdata;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] nxt(input logic [15:0] old, input int b, input logic [15:0] d);
        if (clr_en[b]) return 16'h0000;
        if (write_en[b]) return d;
        if (inc_en[b]) return old + 16'd1;
        return old;
    endfunction

    task automatic model_zero();
        {m_pc, m_ar, m_ir, m_ac, m_r, m_r1, m_r2, m_r3, m_r4, m_dr} = '0;
    endtask

    task automatic drive(input logic [3:0] re, input logic [15:0] we, input logic [15:0] ie,
                         input logic [15:0] ce, input logic [2:0] op, input logic [15:0] imd);
        @(negedge clk);
        read_en = re; write_en = we; inc_en = ie; clr_en = ce; alu_op = op;
        im_rdata = imd; dm_rdata = 16'($urandom);
        #1;
    endtask

    task automatic check_model();
        chk("bus", bus, mbus(read_en));
        chk("dm_wdata", dm_wdata, mbus(read_en));
        chk("dm_we", dm_we, write_en[11]);
        chk("im_addr", im_addr, m_pc);
        chk("dm_addr", dm_addr, m_ar);
        chk("instruction", instruction, m_ir % 64);
        chk("z", z, (m_ac == 16'h0000) ? 32'd1 : 32'd0);
    endtask

    task automatic tick();
        logic [15:0] b, alu, n_ac, n_r;
        logic [31:0] prod;
        @(posedge clk);
        if (!rst_n) begin
            model_zero();
            return;
        end
        b = mbus(read_en);
        prod = 32'(m_ac) * 32'(m_r);
        case (alu_op)
            3'd1: alu = m_ac + m_r;
            3'd2: alu = m_ac - m_r;
            3'd3: alu = prod[15:0];
            3'd4: alu = m_ac * 16'd2;
            default: alu = m_ac;
        endcase
        if (clr_en[4]) n_ac = 0;
        else if (write_en[4]) n_ac = b;
        else if (write_en[12]) n_ac = alu;
        else if (inc_en[4]) n_ac = m_ac + 16'd1;
        else n_ac = m_ac;
        if (clr_en[5]) n_r = 0;
        else if (write_en[5]) n_r = b;
        else if (write_en[13]) n_r = m_ac;
        else if (inc_en[5]) n_r = m_r + 16'd1;
        else n_r = m_r;
        m_pc = nxt(m_pc, 1, b);
        m_ar = nxt(m_ar, 2, b);
        m_ir = nxt(m_ir, 3, b);
        m_r4 = nxt(m_r4, 7, b);
        m_r3 = nxt(m_r3, 8, b);
        m_r2 = nxt(m_r2, 9, b);
        m_r1 = nxt(m_r1, 10, b);
        m_ac = n_ac;
        m_r  = n_r;
        m_dr = dm_rdata;
    endtask

    task automatic cycle(input logic [3:0] re, input logic [15:0] we, input logic [15:0] ie,
                         input logic [15:0] ce, input logic [2:0] op, input logic [15:0] imd);
        drive(re, we, ie, ce, op, imd);
        check_model();
        tick();
    endtask

    task automatic load(input int b, input logic [15:0] v);
        cycle(4'd13, 16'd1 << b, 16'd0, 16'd0, 3'd0, v);
    endtask

    task automatic peek(input string tag, input logic [3:0] re, input logic [15:0] exp);
        drive(re, 16'd0, 16'd0, 16'd0, 3'd0, 16'($urandom));
        chk(tag, bus, exp);
        check_model();
        tick();
    endtask

    task automatic alu_case(input string tag, input logic [15:0] a, input logic [15:0] r,
                            input logic [2:0] op, input logic [15:0] exp);
        load(4, a);
        load(5, r);
        cycle(4'd0, 16'd1 << 12, 16'd0, 16'd0, op, 16'd0);
        peek(tag, 4'd5, exp);
    endtask

    initial begin
        model_zero();
        #3;
        rst_n = 1'b1;

        // reset mid-run with a non-zero AC
        load(4, 16'h1234);
        load(2, 16'h0055);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        read_en = 4'd5; write_en = 16'd1 << 11;
        #1;
        model_zero();
        chk("rst_bus", bus, 16'h0000);
        chk("rst_z", z, 16'h0001);
        chk("rst_instr", instruction, 6'h00);
        chk("rst_im_addr", im_addr, 16'h0000);
        chk("rst_dm_addr", dm_addr, 16'h0000);
        chk("rst_dm_we", dm_we, 1'b1);
        cycle(4'd5, 16'hFFFF, 16'h0000, 16'h0000, 3'd1, 16'hBEEF);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        peek("post_rst_ac", 4'd5, 16'h0000);
        peek("post_rst_ar", 4'd2, 16'h0000);

        // fetch
        cycle(4'd13, 16'd1 << 3, 16'd1 << 1, 16'd0, 3'd0, 16'h0053);
        drive(4'd1, 16'd0, 16'd0, 16'd0, 3'd0, 16'd0);
        chk("fetch_instr", instruction, 6'h13);
        chk("fetch_pc", bus, 16'h0001);
        check_model();
        tick();

        // priority on PC
        cycle(4'd13, 16'd2, 16'd2, 16'd2, 3'd0, 16'h0040);
        peek("prio_clr", 4'd1, 16'h0000);
        cycle(4'd13, 16'd2, 16'd2, 16'd0, 3'd0, 16'h0040);
        peek("prio_wr", 4'd1, 16'h0040);

        // ALU
        alu_case("alu_add", 16'd5, 16'd3, 3'd1, 16'd8);
        alu_case("alu_sub", 16'd5, 16'd3, 3'd2, 16'd2);
        alu_case("alu_mul", 16'd5, 16'd3, 3'd3, 16'd15);
        alu_case("alu_lsh", 16'h8001, 16'd3, 3'd4, 16'h0002);
        alu_case("alu_nop", 16'h1111, 16'd3, 3'd6, 16'h1111);
        alu_case("alu_neg", 16'd3, 16'd5, 3'd2, 16'hFFFE);
        chk("neg_z", z, 16'h0000);

        // wrap
        load(4, 16'hFFFF);
        cycle(4'd0, 16'd0, 16'd1 << 4, 16'd0, 3'd0, 16'd0);
        peek("ac_wrap", 4'd5, 16'h0000);
        chk("wrap_z", z, 16'h0001);
        load(1, 16'hFFFF);
        cycle(4'd0, 16'd0, 16'd1 << 1, 16'd0, 3'd0, 16'd0);
        peek("pc_wrap", 4'd1, 16'h0000);

        // store then load
        load(2, 16'h0007);
        load(4, 16'h5A5A);
        drive(4'd5, 16'd1 << 11, 16'd0, 16'd0, 3'd0, 16'd0);
        chk("st_we", dm_we, 1'b1);
        chk("st_addr", dm_addr, 16'h0007);
        chk("st_wdata", dm_wdata, 16'h5A5A);
        check_model();
        tick();
        drive(4'd12, 16'd1 << 4, 16'd0, 16'd0, 3'd0, 16'd0);
        dm_rdata = 16'h00AB;
        #1;
        check_model();
        tick();
        peek("ld_ac", 4'd5, 16'h00AB);

        // AC -> R and R1-R4 routing
        cycle(4'd0, 16'd1 << 13, 16'd0, 16'd0, 3'd0, 16'd0);
        peek("ac_to_r", 4'd6, 16'h00AB);
        load(10, 16'h0A01);
        load(7, 16'h0A04);
        peek("r1", 4'd7, 16'h0A01);
        peek("r4", 4'd10, 16'h0A04);

        // random phase
        for (int i = 0; i < 600; i++) begin
            cycle(4'($urandom_range(0, 15)),
                  16'($urandom & $urandom),
                  16'($urandom & $urandom),
                  16'($urandom & $urandom & $urandom),
                  3'($urandom_range(0, 7)),
                  16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/datapath_bus.md
# datapath_bus

Register-file and shared-bus datapath driven by the processor control FSM. Decodes `read_en` into a single bus source, and applies `write_en`/`inc_en`/`clr_en`/`alu_op` to the architectural registers (PC, AR, IR, AC, R, R1–R4). Returns the opcode and zero flag to the controller, and drives the external instruction and data memories.

## Interface
- `DATA_W`, 16, width of bus, AC, R, R1–R4, IR and memory data.
- `ADDR_W`, 16, width of PC and AR, and of the memory address ports (ADDR_W ≤ DATA_W).
- `clk`  in  1  system clock; all registers update on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `read_en`  in  4  bus source select.
- `write_en`  in  16  per-register load strobes.
- `inc_en`  in  16  per-register increment strobes.
- `clr_en`  in  16  per-register clear strobes.
- `alu_op`  in  3  ALU operation select.
- `im_rdata`  in  DATA_W  instruction memory read data (combinational read).
- `dm_rdata`  in  DATA_W  data memory read data (combinational read).
- `im_addr`  out  ADDR_W  = PC.
- `dm_addr`  out  ADDR_W  = AR.
- `dm_wdata`  out  DATA_W  = bus.
- `dm_we`  out  1  = write_en[11].
- `instruction`  out  6  = IR[5:0].
- `z`  out  16  {15'b0, AC==0}.
- `bus`  out  DATA_W  current bus value (debug/observe).

## Operation
- Bus mux, combinational, by `read_en`:
  - 0: bus = 0.
  - 1: PC, zero-extended.
  - 2: AR, zero-extended.
  - 3: DR.
  - 4: {6'b0, IR[DATA_W-1:6]} (operand field).
  - 5: AC. 6: R. 7–10: R1–R4.
  - 11: 0 (reserved).
  - 12: dm_rdata. 13: im_rdata.
  - 14–15: 0.
- Strobe bit map, shared by write/inc/clr:
  - 1 PC, 2 AR, 3 IR, 4 AC, 5 R.
  - 7 R4, 8 R3, 9 R2, 10 R1.
  - write_en only: 11 DM write, 12 ALU→AC, 13 AC→R.
  - Unlisted bits are ignored.
- Per-register priority, evaluated each posedge: clr > write > inc > hold.
  - A written value is bus[ADDR_W-1:0] for PC/AR and the full bus for all other registers.
- AC priority: clr_en[4] > write_en[4] > write_en[12] (ALU result) > inc_en[4] > hold.
- R priority: clr_en[5] > write_en[5] > write_en[13] (R ← AC) > inc_en[5] > hold.
- ALU, combinational, result truncated to DATA_W (wraps, no carry out):
  - 1: AC+R.
  - 2: AC−R (two's complement wrap).
  - 3: low DATA_W bits of AC×R.
  - 4: AC<<1.
  - 0 and 5–7: AC (no change).
- DR loads dm_rdata every cycle (one-cycle-delayed copy).
- Increment wraps: all-ones + 1 = 0, for both PC and AC.
- `z` reflects the registered AC; it is not derived from the bus.

## Timing
- Controller outputs change on negedge; this block samples on the following posedge, a half-cycle setup budget.
- Register latency: a strobe active in the state presented at posedge N takes effect after posedge N. The new value is visible on `bus`, `z`, `instruction`, `im_addr` and `dm_addr` in the next controller state.
- DM write: `dm_we`, `dm_addr` and `dm_wdata` are combinational. The memory captures them on the posedge during which `dm_we` is high.
- Reset (rst_n low, at any time, including mid-instruction) clears PC, AR, IR, AC, R, R1–R4 and DR to 0 immediately. While reset is asserted:
  - `z` = 1, `instruction` = 0, `im_addr` = `dm_addr` = 0.
  - `bus` = 0 while read_en ∈ {0–11, 14, 15}.
  - `dm_we` follows write_en[11].
- Simultaneous strobes on different registers are independent and all take effect in the same cycle.

## Structure
- Package `proc_pkg`:
  - read_en source codes (SRC_NONE … SRC_IM).
  - Strobe bit indices (EN_PC … EN_ALU_AC, EN_AC_R).
  - ALU op codes (ALU_NOP, ALU_ADD, ALU_SUB, ALU_MUL, ALU_LSH).
  - Shared with the control FSM.
- One sub-module, `bus_reg`: parameterised width, with clr/load/inc priority and asynchronous active-low reset. Instantiated for PC, AR, IR, R1–R4.
- AC, R and the ALU are coded in the top level because they have extra load sources.

## Test plan
- Reset: assert rst_n=0 with AC=0x1234 → all registers 0 immediately, z[0]=1; release reset → registers hold 0.
- Fetch: im_rdata=0x0053, read_en=13, write_en[3], inc_en[1] with PC=0 → IR=0x0053, PC=1, instruction=6'h13.
- Priority: clr_en[1] + write_en[1] + inc_en[1] with bus=0x0040 → PC=0. Then write_en[1] + inc_en[1] → PC=0x0040.
- ALU: AC=5, R=3 → alu_op=1 gives 8, alu_op=2 gives 2, alu_op=3 gives 15. AC=0x8001 with alu_op=4 → 0x0002. AC=3, R=5 with alu_op=2 → 0xFFFE, z[0]=0.
- Wrap and zero flag: AC=0xFFFF, inc_en[4] → AC=0, z=16'h0001. PC=0xFFFF, inc_en[1] → PC=0.
- Store/load: AR=0x0007, read_en=5, write_en[11] → dm_we=1, dm_addr=7, dm_wdata=AC. Then read_en=12, write_en[4] with dm_rdata=0x00AB → AC=0x00AB.
